// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: run control, upstream op stream and ALU enable bundle
interface alu_op_sequencer_if #(parameter int OPW = 4, parameter int CW = 8);
   logic start;
   logic [CW-1:0] num_ops;
   logic hold;
   logic op_valid;
   logic [OPW-1:0] op_in;
   logic op_ready;
   logic [OPW-1:0] alu_op;
   logic enA;
   logic enALU;
   logic enC;
   logic busy;
   logic done;
   logic [CW-1:0] op_count;
   modport master (
      output start, num_ops, hold, op_valid, op_in,
      input op_ready, alu_op, enA, enALU, enC, busy, done, op_count
   );
   modport slave (
      input start, num_ops, hold, op_valid, op_in,
      output op_ready, alu_op, enA, enALU, enC, busy, done, op_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: stallable run controller issuing load-A / execute / store-C per opcode
module alu_op_sequencer #(
   parameter int OPW = 4,
   parameter int CW = 8
) (
   input logic CLKb,
   input logic RST,
   alu_op_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, LOAD_A, EXEC, STORE, DONE} state_t;
   state_t state, nxt;
   logic [OPW-1:0] op_q;
   logic [CW-1:0] cnt, cnt_inc, n_lat;
   assign cnt_inc = cnt + 1'b1;
   always_ff @(posedge CLKb)
      if (RST) begin
         state <= IDLE;
         op_q <= '0;
         cnt <= '0;
         n_lat <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.start) begin
            n_lat <= bus.num_ops;
            cnt <= '0;
         end
         if (state == FETCH && bus.op_valid) op_q <= bus.op_in;
         if (state == STORE && !bus.hold) cnt <= cnt_inc;
      end
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.start) nxt = (bus.num_ops == '0) ? DONE : FETCH;
         FETCH:   if (bus.op_valid) nxt = LOAD_A;
         LOAD_A:  if (!bus.hold) nxt = EXEC;
         EXEC:    if (!bus.hold) nxt = STORE;
         STORE:   if (!bus.hold) nxt = (cnt_inc == n_lat) ? DONE : FETCH;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // a held phase suppresses its enable so each enable fires once per operation
   assign bus.enA = state == LOAD_A && !bus.hold;
   assign bus.enALU = state == EXEC && !bus.hold;
   assign bus.enC = state == STORE && !bus.hold;
   assign bus.op_ready = state == FETCH;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.alu_op = op_q;
   assign bus.op_count = cnt;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: plan-based timeline model, directed table and random runs
module tb_alu_op_sequencer;
   localparam int OPW = 4;
   localparam int CW = 8;
   localparam int EW = 6 + CW + OPW;
   logic CLKb = 0;
   logic RST;
   always #5 CLKb = ~CLKb;
   alu_op_sequencer_if #(.OPW(OPW), .CW(CW)) bus ();
   alu_op_sequencer #(.OPW(OPW), .CW(CW)) dut (.CLKb(CLKb), .RST(RST), .bus(bus.slave));
   typedef struct {
      logic st;
      logic [CW-1:0] n;
      logic v;
      logic h;
      logic [OPW-1:0] op;
      logic [EW-1:0] exp;
   } cyc_t;
   typedef struct {
      int n, wk, wl, hp, hl, done_at, cnt;
   } vec_t;
   cyc_t q[$];
   vec_t tbl[7];
   logic [OPW-1:0] m_aop;
   logic [CW-1:0] m_cnt;
   bit rnd;
   int errors = 0;
   int checks = 0;
   function automatic logic [EW-1:0] act();
      return {bus.op_ready, bus.enA, bus.enALU, bus.enC, bus.busy, bus.done, bus.op_count, bus.alu_op};
   endfunction
   task automatic chk(string nm, int idx, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, a, e);
      end
   endtask
   function automatic logic rb(logic d);
      return rnd ? 1'($urandom_range(0, 1)) : d;
   endfunction
   function automatic logic [CW-1:0] rn();
      return rnd ? CW'($urandom) : CW'(9);
   endfunction
   function automatic logic [OPW-1:0] ro();
      return OPW'($urandom);
   endfunction
   task automatic add(logic st, logic [CW-1:0] n, logic v, logic h, logic [OPW-1:0] op,
                      logic rdy, logic ea, logic eu, logic ec, logic bsy, logic dn);
      cyc_t c;
      c.st = st; c.n = n; c.v = v; c.h = h; c.op = op;
      c.exp = {rdy, ea, eu, ec, bsy, dn, m_cnt, m_aop};
      q.push_back(c);
   endtask
   // timeline: start, then per op [fetch waits, accept, A/ALU/C each after its holds], done, idle
   task automatic build(int n, int wk, int wl, int hp, int hl);
      int w, s;
      logic [OPW-1:0] op;
      q.delete();
      add(1, CW'(n), rb(1), rb(0), ro(), 0, 0, 0, 0, 0, 0);
      m_cnt = '0;
      for (int k = 0; k < n; k++) begin
         w = rnd ? int'($urandom_range(0, 3)) : (k == wk ? wl : 0);
         for (int i = 0; i < w; i++) add(rb(1), rn(), 0, rb(0), ro(), 1, 0, 0, 0, 1, 0);
         op = rnd ? ro() : OPW'(k + 1);
         add(rb(1), rn(), 1, rb(0), op, 1, 0, 0, 0, 1, 0);
         m_aop = op;
         for (int p = 1; p <= 3; p++) begin
            s = rnd ? ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0) : (k == 0 && p == hp ? hl : 0);
            for (int i = 0; i < s; i++) add(rb(1), rn(), rb(1), 1, ro(), 0, 0, 0, 0, 1, 0);
            add(rb(1), rn(), rb(1), 0, ro(), 0, p == 1, p == 2, p == 3, 1, 0);
         end
         m_cnt = m_cnt + 1'b1;
      end
      add(rb(1), rn(), rb(1), rb(1), ro(), 0, 0, 0, 0, 1, 1);
      add(0, rn(), rb(1), rb(1), ro(), 0, 0, 0, 0, 0, 0);
   endtask
   task automatic apply(cyc_t c);
      bus.start = c.st; bus.num_ops = c.n; bus.op_valid = c.v; bus.hold = c.h; bus.op_in = c.op;
   endtask
   task automatic run_plan(int lim, output int done_at);
      done_at = -1;
      for (int i = 0; i < lim; i++) begin
         apply(q[i]);
         @(negedge CLKb);
         chk("cycle", i, 32'(act()), 32'(q[i].exp));
         if (bus.done === 1'b1 && done_at < 0) done_at = i;
         @(posedge CLKb);
         #1;
      end
   endtask
   initial begin
      int d;
      tbl[0] = '{1, 0, 0, 0, 0, 5, 1};
      tbl[1] = '{3, 1, 3, 0, 0, 16, 3};
      tbl[2] = '{1, 0, 0, 2, 2, 7, 1};
      tbl[3] = '{0, 0, 0, 0, 0, 1, 0};
      tbl[4] = '{2, 0, 0, 0, 0, 9, 2};
      tbl[5] = '{4, 2, 1, 3, 1, 19, 4};
      tbl[6] = '{255, 0, 0, 1, 1, 1022, 255};
      RST = 1;
      bus.start = 0; bus.num_ops = '0; bus.op_valid = 0; bus.hold = 0; bus.op_in = '0;
      m_aop = '0; m_cnt = '0;
      repeat (2) @(posedge CLKb);
      #1 RST = 0;
      rnd = 0;
      q.delete();
      for (int i = 0; i < 5; i++) add(0, CW'(3), 1, 0, ro(), 0, 0, 0, 0, 0, 0);
      run_plan(q.size(), d);
      foreach (tbl[t]) begin
         build(tbl[t].n, tbl[t].wk, tbl[t].wl, tbl[t].hp, tbl[t].hl);
         run_plan(q.size(), d);
         chk("done_at", t, 32'(d), 32'(tbl[t].done_at));
         chk("op_count", t, 32'(bus.op_count), 32'(tbl[t].cnt));
      end
      build(4, 0, 0, 0, 0);
      run_plan(8, d);
      apply(q[8]);
      RST = 1;
      @(negedge CLKb);
      chk("store_before_rst", 0, 32'({bus.enC, bus.op_count}), 32'({1'b1, CW'(1)}));
      @(posedge CLKb);
      #1 RST = 0;
      bus.start = 0;
      @(negedge CLKb);
      chk("after_rst", 0, 32'(act()), 32'(0));
      @(posedge CLKb);
      #1;
      m_aop = '0; m_cnt = '0;
      build(1, 0, 0, 0, 0);
      run_plan(q.size(), d);
      chk("done_at_post_rst", 0, 32'(d), 32'(5));
      rnd = 1;
      for (int r = 0; r < 25; r++) begin
         build(int'($urandom_range(0, 6)), 0, 0, 0, 0);
         run_plan(q.size(), d);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
